// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data-memory bus.
// DATA stores queue bytes in a FIFO; STATUS exposes {overflow, full, empty, busy}.
module dmem_uart_tx #(
  parameter int              DW        = 16,
  parameter logic [DW-1:0]   BASE_ADDR = 16'hFF00,
  parameter int              CLK_DIV   = 434,
  parameter int              FIFO_AW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd,
  output logic          hit,
  output logic          tx,
  output logic          busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(CLK_DIV);
  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [DW-1:0]    STAT_ADDR = BASE_ADDR + DW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_r;
  logic [BW-1:0]        baud_r;
  logic [2:0]           bit_idx_r;
  logic [7:0]           shift_r;
  logic                 tx_r;
  logic                 busy_r;
  logic [7:0]           mem_r [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_r;
  logic [FIFO_AW-1:0]   rd_ptr_r;
  logic [FIFO_AW:0]     count_r;
  logic                 overflow_r;

  logic hit_data_s, hit_stat_s;
  logic full_s, empty_s, baud_end_s;
  logic pop_s, push_req_s, push_ok_s;
  logic [7:0] head_s;
  logic unused_s;

  // Upper write-data bits carry no meaning for either register.
  assign unused_s = ^wd[DW-1:8];

  // Address decode, status read mux and FIFO handshake terms.
  always_comb begin
    hit_data_s = (addr == BASE_ADDR);
    hit_stat_s = (addr == STAT_ADDR);
    hit        = hit_data_s | hit_stat_s;
    full_s     = (count_r == DEPTH_C);
    empty_s    = (count_r == '0);
    baud_end_s = (baud_r == BAUD_LAST);
    head_s     = mem_r[rd_ptr_r];
    // A pop happens only when a byte is waiting, so the FIFO cannot underflow.
    pop_s      = !empty_s && ((state_r == S_IDLE) || ((state_r == S_STOP) && baud_end_s));
    push_req_s = we && hit_data_s;
    push_ok_s  = push_req_s && (!full_s || pop_s);
    if (hit_stat_s) begin
      rd = {{(DW-4){1'b0}}, overflow_r, full_s, empty_s, busy_r};
    end else begin
      rd = '0;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (FIFO_AW + 1)'(1);
        2'b01:   count_r <= count_r - (FIFO_AW + 1)'(1);
        default: count_r <= count_r;
      endcase
      if (push_req_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end else if (we && hit_stat_s && wd[0]) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wd[7:0];
  end

  // Serializer: START/DATA/STOP bit timing with registered tx and busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      baud_r    <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          baud_r <= '0;
          if (pop_s) begin
            shift_r <= head_s;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= S_START;
          end
        end
        S_START: begin
          if (baud_end_s) begin
            baud_r    <= '0;
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
            shift_r   <= {1'b0, shift_r[7:1]};
            state_r   <= S_DATA;
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_end_s) begin
            baud_r <= '0;
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= S_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        S_STOP: begin
          if (baud_end_s) begin
            baud_r <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop_s) begin
              shift_r <= head_s;
              tx_r    <= 1'b0;
              state_r <= S_START;
            end else begin
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= S_IDLE;
            end
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
          baud_r  <= '0;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Directed bench for dmem_uart_tx (CLK_DIV=4, depth 8); a line monitor
// decodes frames into a queue of {stop, data} for comparison.
module tb_dmem_uart_tx;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] STAT = 16'hFF01;

  logic        clk;
  logic        reset;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wd;
  logic [15:0] rd;
  logic        hit;
  logic        tx;
  logic        busy;

  int n_pass;
  int n_fail;
  int n_total;

  logic [8:0] rx_q[$];
  logic [7:0] mon_b;
  logic       mon_sb;
  logic [9:0] pat;
  logic [7:0] bv;

  dmem_uart_tx #(
    .DW(16),
    .BASE_ADDR(16'hFF00),
    .CLK_DIV(4),
    .FIFO_AW(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .addr(addr),
    .wd(wd),
    .rd(rd),
    .hit(hit),
    .tx(tx),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] b);
    logic [8:0] got;
    got = 9'h000;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    check(tag, {7'b0, got}, {7'b0, 1'b1, b});
  endtask

  // Line monitor: sample mid-bit (cycle 2 of 4) and record {stop, data}.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tx === 1'b0) begin
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(posedge clk);
          #2;
          mon_b[i] = tx;
        end
        repeat (4) @(posedge clk);
        #2;
        mon_sb = tx;
        rx_q.push_back({mon_sb, mon_b});
      end
    end
  end

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    reset = 1'b1; we = 1'b0; addr = 16'h0000; wd = 16'h0000;
    #3 reset = 1'b0;
    #1;
    check("rst_tx", {15'b0, tx}, 16'h0001);
    check("rst_busy", {15'b0, busy}, 16'h0000);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    step();
    addr = STAT; #1;
    check("rst_status", rd, 16'h0002);
    check("rst_hit", {15'b0, hit}, 16'h0001);

    // 1. single byte 0x55 with upper data bits set (ignored)
    we = 1'b1; addr = BASE; wd = 16'hAB55;
    step();
    we = 1'b0; addr = 16'h0000;
    check("t1_tx_before_e1", {15'b0, tx}, 16'h0001);
    check("t1_busy_before_e1", {15'b0, busy}, 16'h0000);
    step();
    pat = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("t1_tx_bit%0d_c%0d", k, c), {15'b0, tx}, {15'b0, pat[k]});
        check($sformatf("t1_busy_bit%0d_c%0d", k, c), {15'b0, busy}, 16'h0001);
        step();
      end
    end
    check("t1_busy_e41", {15'b0, busy}, 16'h0000);
    check("t1_tx_e41", {15'b0, tx}, 16'h0001);
    expect_frame("t1_frame", 8'h55);
    check("t1_q_empty", 16'(rx_q.size()), 16'h0000);

    // 2. back-to-back 0xA3, 0x0F
    we = 1'b1; addr = BASE; wd = 16'h00A3;
    step();
    wd = 16'h000F;
    step();
    we = 1'b0; addr = 16'h0000;
    check("t2_start1", {15'b0, tx}, 16'h0000);
    repeat (39) step();
    check("t2_stop_end", {15'b0, tx}, 16'h0001);
    step();
    check("t2_no_gap_tx", {15'b0, tx}, 16'h0000);
    check("t2_no_gap_busy", {15'b0, busy}, 16'h0001);
    repeat (39) step();
    check("t2_busy_e80", {15'b0, busy}, 16'h0001);
    step();
    check("t2_busy_e81", {15'b0, busy}, 16'h0000);
    check("t2_tx_e81", {15'b0, tx}, 16'h0001);
    expect_frame("t2_frame_a3", 8'hA3);
    expect_frame("t2_frame_0f", 8'h0F);
    check("t2_q_empty", 16'(rx_q.size()), 16'h0000);

    // 3. overflow: ten writes, nine accepted
    for (int i = 0; i < 10; i++) begin
      bv = 8'hC0 + 8'(i);
      we = 1'b1; addr = BASE; wd = {8'h5A, bv};
      step();
    end
    we = 1'b0; addr = STAT; #1;
    // {overflow, full, empty, busy}
    check("t3_status_ovf", rd, 16'h000D);
    check("t3_hit_stat", {15'b0, hit}, 16'h0001);
    we = 1'b1; wd = 16'h0001;
    step();
    we = 1'b0; #1;
    check("t3_status_clr", rd, 16'h0005);
    addr = 16'h0000;
    repeat (360) step();
    check("t3_busy_done", {15'b0, busy}, 16'h0000);
    addr = STAT; #1;
    check("t3_status_idle", rd, 16'h0002);
    addr = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      bv = 8'hC0 + 8'(i);
      expect_frame($sformatf("t3_frame%0d", i), bv);
    end
    check("t3_q_empty", 16'(rx_q.size()), 16'h0000);

    // 4. decode misses
    we = 1'b1; addr = 16'hFF02; wd = 16'h0077; #1;
    check("t4_hit_ff02", {15'b0, hit}, 16'h0000);
    check("t4_rd_ff02", rd, 16'h0000);
    step();
    addr = 16'h0000; #1;
    check("t4_hit_0000", {15'b0, hit}, 16'h0000);
    check("t4_rd_0000", rd, 16'h0000);
    step();
    we = 1'b0; addr = STAT; #1;
    check("t4_status", rd, 16'h0002);
    check("t4_hit_stat", {15'b0, hit}, 16'h0001);
    addr = BASE; #1;
    check("t4_rd_data", rd, 16'h0000);
    check("t4_hit_data", {15'b0, hit}, 16'h0001);
    addr = 16'h0000;
    repeat (50) step();
    check("t4_busy", {15'b0, busy}, 16'h0000);
    check("t4_no_frames", 16'(rx_q.size()), 16'h0000);

    // 5. reset during DATA bit 3 (bit3 of 0x37 is 0) with two bytes queued
    we = 1'b1; addr = BASE; wd = 16'h0037;
    step();
    wd = 16'h0081;
    step();
    wd = 16'h0042;
    step();
    we = 1'b0; addr = 16'h0000;
    repeat (16) step();
    check("t5_tx_bit3", {15'b0, tx}, 16'h0000);
    check("t5_busy_bit3", {15'b0, busy}, 16'h0001);
    #2 reset = 1'b0;
    #1;
    check("t5_tx_async", {15'b0, tx}, 16'h0001);
    check("t5_busy_async", {15'b0, busy}, 16'h0000);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    step();
    addr = STAT; #1;
    check("t5_status_after", rd, 16'h0002);
    addr = 16'h0000;
    repeat (40) step();
    rx_q.delete();
    repeat (60) step();
    check("t5_no_frames", 16'(rx_q.size()), 16'h0000);
    check("t5_busy_idle", {15'b0, busy}, 16'h0000);
    check("t5_tx_idle", {15'b0, tx}, 16'h0001);

    // 6. full FIFO with a write on the STOP-end pop edge
    for (int i = 0; i < 9; i++) begin
      bv = 8'h90 + 8'(i);
      we = 1'b1; addr = BASE; wd = {8'h00, bv};
      step();
    end
    we = 1'b0; addr = STAT; #1;
    check("t6_full", rd, 16'h0005);
    repeat (32) step();
    check("t6_full_e40", rd, 16'h0005);
    we = 1'b1; addr = BASE; wd = 16'h00E7;
    step();
    we = 1'b0; addr = STAT; #1;
    check("t6_after_pop_push", rd, 16'h0005);
    addr = 16'h0000;
    repeat (380) step();
    check("t6_busy_done", {15'b0, busy}, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      bv = 8'h90 + 8'(i);
      expect_frame($sformatf("t6_frame%0d", i), bv);
    end
    expect_frame("t6_frame_e7", 8'hE7);
    check("t6_q_empty", 16'(rx_q.size()), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
